// File: rtl/noc_pkg.sv
// Shared mesh-NoC definitions: packet field layout, router direction codes,
// injector FSM states and the packet assembly helper.
package noc_pkg;

  localparam int PKT_W     = 40;
  localparam int SRC_MSB   = 39;
  localparam int SRC_LSB   = 38;
  localparam int DST_MSB   = 37;
  localparam int DST_LSB   = 36;
  localparam int SEQ_MSB   = 35;
  localparam int SEQ_LSB   = 32;
  localparam int PAYLOAD_W = 32;
  localparam int ADDR_W    = 2;
  localparam int ENTRY_W   = ADDR_W + PAYLOAD_W;

  localparam logic [1:0] DIR_RST   = 2'b00;
  localparam logic [1:0] DIR_X     = 2'b01;
  localparam logic [1:0] DIR_Y     = 2'b10;
  localparam logic [1:0] DIR_LOCAL = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } inj_state_t;

  function automatic logic [PKT_W-1:0] build_pkt(
    input logic [ADDR_W-1:0]          src,
    input logic [ADDR_W-1:0]          dst,
    input logic [SEQ_MSB-SEQ_LSB:0]   seq,
    input logic [PAYLOAD_W-1:0]       payload
  );
    return {src, dst, seq, payload};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read and an occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is not reset; the level counter alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/packet_injector.sv
// Source-side network interface: queues core requests and emits stamped
// 40-bit packets {src, dst, seq, payload} over a valid/ready link.
module packet_injector
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int SEQ_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               current_location,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_dst,
  input  logic [31:0]              req_payload,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic [39:0]              pkt_dout,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               sent_count
);

  inj_state_t           state;
  inj_state_t           state_nxt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   fifo_head;
  logic                 push;
  logic                 pop;
  logic                 xfer;
  logic [SEQ_W-1:0]     seq_cnt;

  // Ready depends only on registered occupancy and the reset pin, never on pkt_ready.
  assign req_ready = rst_n && !fifo_full;
  assign push      = req_valid && req_ready;
  assign pkt_valid = (state == ST_SEND);
  assign xfer      = pkt_valid && pkt_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({req_dst, req_payload}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pkt_ready) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pkt_dout   <= '0;
      seq_cnt    <= '0;
      sent_count <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        pkt_dout <= build_pkt(current_location,
                              fifo_head[ENTRY_W-1:PAYLOAD_W],
                              seq_cnt,
                              fifo_head[PAYLOAD_W-1:0]);
        seq_cnt  <= seq_cnt + SEQ_W'(1);
      end
      if (xfer) sent_count <= sent_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_packet_injector.sv
// Scoreboard bench for packet_injector: the driver predicts each accepted
// request's packet, a monitor pops and compares on every handshake.
module tb_packet_injector;
  import noc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  current_location = 2'b00;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_dst = 2'b00;
  logic [31:0] req_payload = 32'h0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [39:0] pkt_dout;
  logic [2:0]  fifo_level;
  logic [7:0]  sent_count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [39:0] exp_q[$];
  int          acc_count = 0;
  int          sent_model = 0;
  int          xfer_total = 0;
  logic [1:0]  loc = 2'b00;
  logic        stall_prev = 1'b0;
  logic [39:0] dout_prev = '0;

  packet_injector #(.DEPTH(4), .SEQ_W(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .current_location (current_location),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_dst          (req_dst),
    .req_payload      (req_payload),
    .pkt_valid        (pkt_valid),
    .pkt_ready        (pkt_ready),
    .pkt_dout         (pkt_dout),
    .fifo_level       (fifo_level),
    .sent_count       (sent_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed handshake against the predicted queue
  // and checks that a stalled packet is held unchanged.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("hold_valid", 64'(pkt_valid), 64'd1);
        check("hold_dout", 64'(pkt_dout), 64'(dout_prev));
      end
      if (pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pkt: got %0h expected none", pkt_dout);
        end else begin
          check("pkt_dout", 64'(pkt_dout), 64'(exp_q.pop_front()));
        end
        xfer_total++;
        sent_model = (sent_model + 1) % 256;
      end
      stall_prev <= pkt_valid && !pkt_ready;
      dout_prev  <= pkt_dout;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // One cycle of stimulus; the expected packet is queued when the request
  // is seen to be accepted. Requests are stamped with seq in acceptance order.
  task automatic step(input logic v, input logic [1:0] d, input logic [31:0] p, input logic pr);
    @(posedge clk);
    #1;
    req_valid   = v;
    req_dst     = d;
    req_payload = p;
    pkt_ready   = pr;
    @(negedge clk);
    if (req_valid && req_ready) begin
      exp_q.push_back({loc, req_dst, 4'(acc_count % 16), req_payload});
      acc_count++;
    end
  endtask

  task automatic do_reset(input logic [1:0] l);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    pkt_ready = 1'b0;
    loc = l;
    current_location = l;
    #1;
    check("rst_pkt_valid", 64'(pkt_valid), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_pkt_dout", 64'(pkt_dout), 64'd0);
    check("rst_sent_count", 64'(sent_count), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    acc_count = 0;
    sent_model = 0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || pkt_valid) && guard < 60) begin
      step(1'b0, 2'b00, 32'h0, 1'b1);
      guard++;
    end
    if (guard >= 60) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    check("sent_count", 64'(sent_count), 64'(sent_model));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int t0;
    int guard;
    logic [1:0] d;

    // Single request, first-packet latency and content
    do_reset(2'b01);
    step(1'b1, 2'b10, 32'hDEADBEEF, 1'b1);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    check("lat_not_yet", 64'(pkt_valid), 64'd0);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    check("lat_valid", 64'(pkt_valid), 64'd1);
    check("first_pkt", 64'(pkt_dout), 64'h60DEADBEEF);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    check("one_cycle_valid", 64'(pkt_valid), 64'd0);
    check("first_sent", 64'(sent_count), 64'd1);

    // Backpressure
    step(1'b1, 2'b11, $urandom, 1'b0);
    guard = 0;
    while (!pkt_valid && guard < 5) begin
      step(1'b0, 2'b00, 32'h0, 1'b0);
      guard++;
    end
    check("bp_valid_rise", 64'(pkt_valid), 64'd1);
    repeat (5) step(1'b0, 2'b00, 32'h0, 1'b0);
    s0 = int'(sent_count);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    step(1'b0, 2'b00, 32'h0, 1'b0);
    check("bp_done", 64'(pkt_valid), 64'd0);
    check("bp_sent_once", 64'(sent_count), 64'((s0 + 1) % 256));

    // Sequence wrap over 17 packets
    do_reset(2'b10);
    for (int i = 0; i < 17; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b1);
    drain();
    check("wrap_sent17", 64'(sent_count), 64'd17);

    // Fill under backpressure, then back-to-back release
    do_reset(2'b11);
    for (int i = 0; i < 6; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b0);
    check("fill_accepted", 64'(acc_count), 64'd5);
    check("fill_level", 64'(fifo_level), 64'd4);
    check("fill_req_ready", 64'(req_ready), 64'd0);
    t0 = xfer_total;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 32'h0, 1'b1);
      check("b2b_valid", 64'(pkt_valid), 64'd1);
    end
    step(1'b0, 2'b00, 32'h0, 1'b1);
    check("b2b_idle", 64'(pkt_valid), 64'd0);
    check("b2b_count", 64'(xfer_total - t0), 64'd5);
    drain();

    // Steady simultaneous push/pop, including self-addressed requests
    t0 = xfer_total;
    for (int i = 0; i < 20; i++) begin
      d = (i % 4 == 0) ? loc : 2'($urandom_range(0, 3));
      step(1'b1, d, $urandom, 1'b1);
      if (i >= 1) check("steady_level", 64'(fifo_level), 64'd1);
      if (i >= 2) check("steady_valid", 64'(pkt_valid), 64'd1);
    end
    #1;
    check("steady_throughput", 64'(xfer_total - t0), 64'd18);
    drain();

    // Randomized traffic
    do_reset(2'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 3) != 0));
    drain();

    // Reset in the middle of a stalled transfer with three entries queued
    for (int i = 0; i < 4; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b0);
    step(1'b0, 2'b00, 32'h0, 1'b0);
    check("mid_level", 64'(fifo_level), 64'd3);
    check("mid_valid", 64'(pkt_valid), 64'd1);
    do_reset(2'b00);
    step(1'b1, 2'b01, 32'h12345678, 1'b1);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    step(1'b0, 2'b00, 32'h0, 1'b1);
    check("post_rst_pkt", 64'(pkt_dout), 64'h1012345678);
    drain();
    check("post_rst_sent", 64'(sent_count), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_injector.md
Name: packet_injector

Overview:
- Source-side network interface for the mesh router: takes routing requests from the local core, assembles 40-bit packets, and presents them to the router input.
- Stamps its own location as the source field and a per-node sequence number on every packet.
- Buffers up to DEPTH requests and drives the packet link with a valid/ready handshake; holds the packet stable under backpressure.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- SEQ_W, 4, sequence-number width; fixed to the 4-bit packet field, other values unsupported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- current_location  input  2  this node's address; static after reset.
- req_valid  input  1  core offers a request.
- req_ready  output  1  injector can accept; equals FIFO not full.
- req_dst  input  2  destination node address.
- req_payload  input  32  payload word.
- pkt_valid  output  1  pkt_dout holds a valid packet.
- pkt_ready  input  1  router accepts the packet this cycle.
- pkt_dout  output  40  {src[39:38], dst[37:36], seq[35:32], payload[31:0]}.
- fifo_level  output  3  occupied FIFO entries (0..DEPTH), width = clog2(DEPTH)+1.
- sent_count  output  8  packets handed to the router; wraps 255->0.

Behaviour:
- Reset: this state applies immediately when rst_n is asserted, mid-transfer included.
  - req_ready=0 while in reset; req_ready=1 on the first cycle after release.
  - pkt_valid=0, pkt_dout=40'h0, fifo_level=0, sent_count=0, seq counter=0, FSM in IDLE.
  - FIFO contents are discarded and any in-flight packet is lost.
- Request accept: occurs when req_valid && req_ready on a rising edge. The entry stores {req_dst, req_payload}; source and sequence number are not stored.
- FSM states:
  - IDLE: pkt_valid=0. If the FIFO is non-empty, pop the head, build the packet, register it into pkt_dout, and go to SEND.
  - SEND: pkt_valid=1. If pkt_ready=0, stay in SEND with pkt_dout held bit-stable.
  - SEND, pkt_ready=1, FIFO non-empty: complete the transfer; in the same cycle pop the next head and load it. Stay in SEND (back-to-back, one packet per cycle).
  - SEND, pkt_ready=1, FIFO empty: complete the transfer and go to IDLE.
- Packet build at pop time:
  - src = current_location.
  - seq = seq counter value; the counter increments on each pop and wraps 15->0.
- Latency: a request accepted at edge N into an empty FIFO with the FSM in IDLE appears on pkt_dout with pkt_valid=1 after edge N+1. There is no combinational path from req_* to pkt_*.
- Transfer complete: pkt_valid && pkt_ready. sent_count increments by 1 and wraps.
- fifo_level: +1 on accept, -1 on pop, unchanged on a simultaneous accept and pop.
- Full FIFO: req_ready=0 and requests are ignored. A push is still allowed in a cycle where a pop frees an entry only if req_ready was already 1; req_ready is never combinationally derived from pkt_ready.
- Empty FIFO, pkt_ready=1 in IDLE: no effect.
- Self-addressed request (req_dst == current_location): sent normally; the router resolves it as direction Local (2'b11).
- pkt_dout content is don't-care to the receiver while pkt_valid=0 but is held at its last value. It is reset to 0 only by rst_n.

Decomposition:
- Shared package noc_pkg holds:
  - Constants PKT_W=40, SRC_MSB=39, SRC_LSB=38, DST_MSB=37, DST_LSB=36, SEQ_MSB=35, SEQ_LSB=32, PAYLOAD_W=32.
  - Direction codes DIR_RST=2'b00, DIR_X=2'b01, DIR_Y=2'b10, DIR_LOCAL=2'b11.
  - The FSM state enum.
- Sub-module sync_fifo (width 34, DEPTH entries) with push/pop/full/empty/level. The injector instantiates it and keeps the FSM, packet build, and counters.

Test Plan:
- Reset then single request: at location 2'b01, push dst=2'b10, payload=32'hDEADBEEF with pkt_ready=1. One cycle later pkt_dout=40'h6_0DEADBEEF (src 01, dst 10, seq 0), pkt_valid=1 for exactly one cycle; sent_count=1.
- Backpressure: hold pkt_ready=0 for 5 cycles after pkt_valid rises. pkt_dout stays bit-stable. Raising pkt_ready gives exactly one transfer and sent_count increments once.
- Fill: with pkt_ready=0, push 6 requests. Requests are accepted until fifo_level=4 (one packet in SEND plus 4 queued → 5 accepted), then req_ready=0. Release pkt_ready: 5 back-to-back packets with seq 0..4 in order, one per cycle.
- Sequence wrap: send 17 packets. seq runs 0..15 then 0; sent_count=17.
- Simultaneous push/pop: steady req_valid=1, pkt_ready=1 for 20 cycles. fifo_level stays constant, throughput is 1 packet/cycle after initial latency, payload order is preserved.
- Mid-operation reset: assert rst_n=0 while in SEND with 3 entries queued. pkt_valid drops immediately (asynchronous), fifo_level=0; after release the first new packet carries seq 0.
